// File: rtl/nn_pkg.sv
// ============================================================================
// Module   : nn_pkg
// Purpose  : Shared constants and FSM state type for the weight-update path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nn_pkg;
    localparam int          FP_MULT_LAT = 5;
    localparam int          FP_ADD_LAT  = 7;
    localparam logic [31:0] FP_ONE      = 32'h3f800000;
    localparam logic [31:0] FP_QNAN     = 32'h7fc00000;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        ADD  = 3'd2,
        WB   = 3'd3,
        DONE = 3'd4
    } state_e;
endpackage

`default_nettype wire

// File: rtl/fp_adder.sv
// ============================================================================
// Module   : fp_adder
// Purpose  : IEEE-754 single add, round-to-nearest-even, LAT-deep pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_adder
    import nn_pkg::*;
#(
    parameter int LAT = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_y
);
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [31:0]        big, sml;
    logic [7:0]         d;
    logic [49:0]        wide;
    logic [26:0]        big_x, sml_x, norm;
    logic [27:0]        sum;
    logic [4:0]         lz;
    logic               found, up;
    logic [24:0]        rnd;
    logic signed [9:0]  exp_n, exp_r;
    logic [31:0]        y_d;
    logic [31:0]        pipe_q [LAT];

    always_comb begin
        a_zero = (i_a[30:23] == 8'd0);
        b_zero = (i_b[30:23] == 8'd0);
        a_inf  = (i_a[30:23] == 8'hff) && (i_a[22:0] == 23'd0);
        b_inf  = (i_b[30:23] == 8'hff) && (i_b[22:0] == 23'd0);
        a_nan  = (i_a[30:23] == 8'hff) && (i_a[22:0] != 23'd0);
        b_nan  = (i_b[30:23] == 8'hff) && (i_b[22:0] != 23'd0);
        big    = (i_b[30:0] > i_a[30:0]) ? i_b : i_a;
        sml    = (i_b[30:0] > i_a[30:0]) ? i_a : i_b;
        d      = big[30:23] - sml[30:23];
        // Three extra bits (guard, round, sticky) carry the shifted-out tail.
        wide   = {1'b1, sml[22:0], 26'd0} >> d;
        sml_x  = {wide[49:24], (|wide[23:0]) | (d > 8'd49)};
        big_x  = {1'b1, big[22:0], 3'b000};
        sum    = (big[31] ^ sml[31]) ? ({1'b0, big_x} - {1'b0, sml_x})
                                     : ({1'b0, big_x} + {1'b0, sml_x});
        lz     = '0;
        found  = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && sum[i]) begin
                lz    = 5'(26 - i);
                found = 1'b1;
            end
        end
        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = $signed({2'b00, big[30:23]}) + 10'sd1;
        end else begin
            norm  = sum[26:0] << lz;
            exp_n = $signed({2'b00, big[30:23]}) - $signed({5'd0, lz});
        end
        up    = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd   = {1'b0, norm[26:3]} + {24'd0, up};
        exp_r = exp_n + (rnd[24] ? 10'sd1 : 10'sd0);

        if (a_nan)                                  y_d = i_a;
        else if (b_nan)                             y_d = i_b;
        else if (a_inf && b_inf && (i_a[31] != i_b[31])) y_d = FP_QNAN;
        else if (a_inf)                             y_d = i_a;
        else if (b_inf)                             y_d = i_b;
        else if (a_zero && b_zero)                  y_d = {i_a[31] & i_b[31], 31'd0};
        else if (a_zero)                            y_d = i_b;
        else if (b_zero)                            y_d = i_a;
        else if (sum == 28'd0)                      y_d = 32'd0;
        else if (exp_r >= 10'sd255)                 y_d = {big[31], 8'hff, 23'd0};
        else if (exp_r <= 10'sd0)                   y_d = {big[31], 31'd0};
        else                                        y_d = {big[31], exp_r[7:0], rnd[22:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= y_d;
            for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign o_y = pipe_q[LAT-1];
endmodule

`default_nettype wire

// File: rtl/fp_multiplier.sv
// ============================================================================
// Module   : fp_multiplier
// Purpose  : IEEE-754 single multiply, round-to-nearest-even, LAT-deep pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_multiplier
    import nn_pkg::*;
#(
    parameter int LAT = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_y
);
    logic               s;
    logic [7:0]         ea, eb;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [47:0]        prod;
    logic [22:0]        mant;
    logic               g, st, up;
    logic [23:0]        rnd;
    logic signed [9:0]  exp_n, exp_r;
    logic [31:0]        y_d;
    logic [31:0]        pipe_q [LAT];

    // Subnormal operands are treated as zero.
    always_comb begin
        s      = i_a[31] ^ i_b[31];
        ea     = i_a[30:23];
        eb     = i_b[30:23];
        a_zero = (ea == 8'd0);
        b_zero = (eb == 8'd0);
        a_inf  = (ea == 8'hff) && (i_a[22:0] == 23'd0);
        b_inf  = (eb == 8'hff) && (i_b[22:0] == 23'd0);
        a_nan  = (ea == 8'hff) && (i_a[22:0] != 23'd0);
        b_nan  = (eb == 8'hff) && (i_b[22:0] != 23'd0);
        prod   = {1'b1, i_a[22:0]} * {1'b1, i_b[22:0]};
        exp_n  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        if (prod[47]) begin
            mant  = prod[46:24];
            g     = prod[23];
            st    = |prod[22:0];
            exp_n = exp_n + 10'sd1;
        end else begin
            mant  = prod[45:23];
            g     = prod[22];
            st    = |prod[21:0];
        end
        up    = g & (st | mant[0]);
        rnd   = {1'b0, mant} + {23'd0, up};
        exp_r = exp_n + (rnd[23] ? 10'sd1 : 10'sd0);

        if (a_nan)                                   y_d = i_a;
        else if (b_nan)                              y_d = i_b;
        else if ((a_inf && b_zero) || (b_inf && a_zero)) y_d = FP_QNAN;
        else if (a_inf || b_inf)                     y_d = {s, 8'hff, 23'd0};
        else if (a_zero || b_zero)                   y_d = {s, 31'd0};
        else if (exp_r >= 10'sd255)                  y_d = {s, 8'hff, 23'd0};
        else if (exp_r <= 10'sd0)                    y_d = {s, 31'd0};
        else                                         y_d = {s, exp_r[7:0], rnd[22:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= y_d;
            for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign o_y = pipe_q[LAT-1];
endmodule

`default_nettype wire

// File: rtl/update_weight_mid.sv
// ============================================================================
// Module   : update_weight_mid
// Purpose  : Sequential w[i] += delta*x[i] for one hidden node (x2 = 1.0 bias).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module update_weight_mid
    import nn_pkg::*;
#(
    parameter logic [31:0] INIT_W0 = 32'h3f000000,
    parameter logic [31:0] INIT_W1 = 32'h3f000000,
    parameter logic [31:0] INIT_W2 = 32'h3f000000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic [31:0] iDELTA,
    input  logic [31:0] iX0,
    input  logic [31:0] iX1,
    input  logic        iLOAD,
    input  logic [1:0]  iLOAD_IDX,
    input  logic [31:0] iLOAD_DATA,
    output logic [31:0] oW0,
    output logic [31:0] oW1,
    output logic [31:0] oW2,
    output logic        oBUSY,
    output logic        oDONE
);
    localparam logic [3:0] MUL_LAST = 4'(FP_MULT_LAT - 1);
    localparam logic [3:0] ADD_LAST = 4'(FP_ADD_LAT - 1);

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] delta_q, delta_d, x0_q, x0_d, x1_q, x1_d;
    logic [31:0] w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
    logic [31:0] x_sel, w_sel, product, sum;

    // Operands stay stable through MUL and ADD, so the cores' outputs are
    // valid once their latency has elapsed without any capture register.
    always_comb begin
        case (idx_q)
            2'd0:    begin x_sel = x0_q;   w_sel = w0_q; end
            2'd1:    begin x_sel = x1_q;   w_sel = w1_q; end
            default: begin x_sel = FP_ONE; w_sel = w2_q; end
        endcase
    end

    fp_multiplier #(.LAT(FP_MULT_LAT)) u_mul (
        .clk (iCLK), .rst (iRST), .i_a (delta_q), .i_b (x_sel), .o_y (product)
    );

    fp_adder #(.LAT(FP_ADD_LAT)) u_add (
        .clk (iCLK), .rst (iRST), .i_a (product), .i_b (w_sel), .o_y (sum)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        delta_d = delta_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        case (state_q)
            IDLE: begin
                if (iLOAD) begin
                    case (iLOAD_IDX)
                        2'd0:    w0_d = iLOAD_DATA;
                        2'd1:    w1_d = iLOAD_DATA;
                        2'd2:    w2_d = iLOAD_DATA;
                        default: ;
                    endcase
                end else if (iSTART) begin
                    delta_d = iDELTA;
                    x0_d    = iX0;
                    x1_d    = iX1;
                    idx_d   = 2'd0;
                    cnt_d   = 4'd0;
                    state_d = MUL;
                end
            end
            MUL: begin
                if (cnt_q == MUL_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = ADD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ADD: begin
                if (cnt_q == ADD_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = WB;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WB: begin
                case (idx_q)
                    2'd0:    w0_d = sum;
                    2'd1:    w1_d = sum;
                    default: w2_d = sum;
                endcase
                if (idx_q == 2'd2) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = MUL;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            delta_q <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            w0_q    <= INIT_W0;
            w1_q    <= INIT_W1;
            w2_q    <= INIT_W2;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            delta_q <= delta_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
        end
    end

    assign oW0   = w0_q;
    assign oW1   = w1_q;
    assign oW2   = w2_q;
    assign oBUSY = (state_q == MUL) || (state_q == ADD) || (state_q == WB);
    assign oDONE = (state_q == DONE);
endmodule

`default_nettype wire

// File: tb/tb_update_weight_mid.sv
// ============================================================================
// Module   : tb_update_weight_mid
// Purpose  : Self-checking bench for update_weight_mid against a real-valued model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_update_weight_mid;
    logic        iCLK;
    logic        iRST;
    logic        iSTART;
    logic [31:0] iDELTA, iX0, iX1;
    logic        iLOAD;
    logic [1:0]  iLOAD_IDX;
    logic [31:0] iLOAD_DATA;
    logic [31:0] oW0, oW1, oW2;
    logic        oBUSY, oDONE;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mw [3];

    localparam logic [31:0] INIT = 32'h3f000000;

    update_weight_mid dut (
        .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iDELTA(iDELTA),
        .iX0(iX0), .iX1(iX1), .iLOAD(iLOAD), .iLOAD_IDX(iLOAD_IDX),
        .iLOAD_DATA(iLOAD_DATA), .oW0(oW0), .oW1(oW1), .oW2(oW2),
        .oBUSY(oBUSY), .oDONE(oDONE)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    function automatic real s2r(input logic [31:0] b);
        real v;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        v = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return b[31] ? -v : v;
    endfunction

    // Stimulus is dyadic with few bits, so every result is exact in single precision.
    function automatic logic [31:0] r2s(input real r);
        real  a;
        int   e;
        int   m;
        logic s;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 127;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        m = int'((a - 1.0) * 8388608.0);
        return {s, e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] rnd_fp(input real scale);
        real r;
        r = real'($urandom_range(0, 15)) / scale;
        if ($urandom_range(0, 1) == 1) r = -r;
        return r2s(r);
    endfunction

    task automatic model_update(input logic [31:0] d, input logic [31:0] x0, input logic [31:0] x1);
        mw[0] = r2s(s2r(mw[0]) + s2r(d) * s2r(x0));
        mw[1] = r2s(s2r(mw[1]) + s2r(d) * s2r(x1));
        mw[2] = r2s(s2r(mw[2]) + s2r(d) * 1.0);
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic do_reset();
        iRST = 1'b1;
        tick();
        tick();
        iRST = 1'b0;
        mw[0] = INIT; mw[1] = INIT; mw[2] = INIT;
    endtask

    task automatic start_update(input logic [31:0] d, input logic [31:0] x0, input logic [31:0] x1);
        iDELTA = d; iX0 = x0; iX1 = x1;
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
    endtask

    // Returns the cycle index at which oDONE was seen (-1 on timeout), then steps into IDLE.
    task automatic wait_done(input int n0, output int lat);
        lat = -1;
        for (int n = n0 + 1; n <= n0 + 100; n++) begin
            tick();
            if (oDONE === 1'b1) begin
                lat = n;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        checks++; if (oW0 !== INIT) begin errors++; $display("FAIL reset_w0: got %h expected %h", oW0, INIT); end
        checks++; if (oW1 !== INIT) begin errors++; $display("FAIL reset_w1: got %h expected %h", oW1, INIT); end
        checks++; if (oW2 !== INIT) begin errors++; $display("FAIL reset_w2: got %h expected %h", oW2, INIT); end
        checks++; if (oBUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", oBUSY); end
        checks++; if (oDONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", oDONE); end
    endtask

    task automatic test_basic();
        int lat;
        do_reset();
        start_update(32'h3e800000, 32'h3f800000, 32'h00000000);
        checks++; if (oBUSY !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", oBUSY); end
        for (int n = 2; n <= 13; n++) tick();
        checks++; if (oW0 !== INIT) begin errors++; $display("FAIL basic_w0_early: got %h expected %h", oW0, INIT); end
        tick();
        checks++; if (oW0 !== 32'h3f400000) begin errors++; $display("FAIL basic_w0_after_wb: got %h expected 3f400000", oW0); end
        wait_done(14, lat);
        checks++; if (lat !== 40) begin errors++; $display("FAIL basic_latency: got %0d expected 40", lat); end
        checks++; if (oW0 !== 32'h3f400000) begin errors++; $display("FAIL basic_w0: got %h expected 3f400000", oW0); end
        checks++; if (oW1 !== 32'h3f000000) begin errors++; $display("FAIL basic_w1: got %h expected 3f000000", oW1); end
        checks++; if (oW2 !== 32'h3f400000) begin errors++; $display("FAIL basic_w2: got %h expected 3f400000", oW2); end
    endtask

    task automatic test_negative();
        int lat;
        do_reset();
        start_update(32'hbe800000, 32'h3f800000, 32'h3f800000);
        wait_done(1, lat);
        checks++; if (lat !== 40) begin errors++; $display("FAIL neg_latency: got %0d expected 40", lat); end
        checks++; if (oW0 !== 32'h3e800000) begin errors++; $display("FAIL neg_w0: got %h expected 3e800000", oW0); end
        checks++; if (oW1 !== 32'h3e800000) begin errors++; $display("FAIL neg_w1: got %h expected 3e800000", oW1); end
        checks++; if (oW2 !== 32'h3e800000) begin errors++; $display("FAIL neg_w2: got %h expected 3e800000", oW2); end
    endtask

    task automatic test_restart_ignored();
        int done_cnt;
        int done_at;
        done_cnt = 0;
        done_at  = -1;
        do_reset();
        model_update(32'h3e000000, 32'h3f800000, 32'h40000000);
        start_update(32'h3e000000, 32'h3f800000, 32'h40000000);
        for (int t = 1; t <= 90; t++) begin
            iSTART = (t == 5) || (t == 39) || (t == 40);
            if (t == 3) begin
                iDELTA = 32'h40400000; iX0 = 32'hc0000000; iX1 = 32'h3f000000;
            end
            tick();
            if (oDONE === 1'b1) begin
                done_cnt++;
                done_at = t + 1;
            end
        end
        iSTART = 1'b0;
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL restart_done_count: got %0d expected 1", done_cnt); end
        checks++; if (done_at !== 40) begin errors++; $display("FAIL restart_done_cycle: got %0d expected 40", done_at); end
        checks++; if (oW0 !== mw[0]) begin errors++; $display("FAIL restart_w0: got %h expected %h", oW0, mw[0]); end
        checks++; if (oW1 !== mw[1]) begin errors++; $display("FAIL restart_w1: got %h expected %h", oW1, mw[1]); end
        checks++; if (oW2 !== mw[2]) begin errors++; $display("FAIL restart_w2: got %h expected %h", oW2, mw[2]); end
        checks++; if (oBUSY !== 1'b0) begin errors++; $display("FAIL restart_busy: got %b expected 0", oBUSY); end
    endtask

    task automatic test_load();
        int lat;
        do_reset();
        iLOAD = 1'b1; iLOAD_IDX = 2'd1; iLOAD_DATA = 32'h40000000;
        start_update(32'h3f800000, 32'h3f800000, 32'h3f800000);
        iLOAD = 1'b0;
        mw[1] = 32'h40000000;
        checks++; if (oW1 !== 32'h40000000) begin errors++; $display("FAIL load_w1: got %h expected 40000000", oW1); end
        checks++; if (oBUSY !== 1'b0) begin errors++; $display("FAIL load_busy_now: got %b expected 0", oBUSY); end
        tick(); tick(); tick();
        checks++; if (oBUSY !== 1'b0) begin errors++; $display("FAIL load_busy_later: got %b expected 0", oBUSY); end
        iLOAD = 1'b1; iLOAD_IDX = 2'd3; iLOAD_DATA = 32'hdeadbeef;
        tick();
        iLOAD = 1'b0;
        tick();
        checks++; if (oW0 !== mw[0]) begin errors++; $display("FAIL load_idx3_w0: got %h expected %h", oW0, mw[0]); end
        checks++; if (oW1 !== mw[1]) begin errors++; $display("FAIL load_idx3_w1: got %h expected %h", oW1, mw[1]); end
        checks++; if (oW2 !== mw[2]) begin errors++; $display("FAIL load_idx3_w2: got %h expected %h", oW2, mw[2]); end
        model_update(32'h3e800000, 32'hbf800000, 32'h3f800000);
        start_update(32'h3e800000, 32'hbf800000, 32'h3f800000);
        for (int t = 2; t <= 10; t++) begin
            iLOAD = (t == 8); iLOAD_IDX = 2'd0; iLOAD_DATA = 32'h41000000;
            tick();
        end
        iLOAD = 1'b0;
        wait_done(10, lat);
        checks++; if (lat !== 40) begin errors++; $display("FAIL busyload_latency: got %0d expected 40", lat); end
        checks++; if (oW0 !== mw[0]) begin errors++; $display("FAIL busyload_w0: got %h expected %h", oW0, mw[0]); end
        checks++; if (oW1 !== mw[1]) begin errors++; $display("FAIL busyload_w1: got %h expected %h", oW1, mw[1]); end
        checks++; if (oW2 !== mw[2]) begin errors++; $display("FAIL busyload_w2: got %h expected %h", oW2, mw[2]); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int done_cnt;
        done_cnt = 0;
        do_reset();
        start_update(32'h3e800000, 32'h3f800000, 32'h3f800000);
        for (int t = 2; t < 20; t++) tick();
        iRST = 1'b1; iSTART = 1'b1; iLOAD = 1'b1; iLOAD_IDX = 2'd0; iLOAD_DATA = 32'h41200000;
        tick();
        iRST = 1'b0; iSTART = 1'b0; iLOAD = 1'b0;
        checks++; if (oW0 !== INIT) begin errors++; $display("FAIL rstmid_w0: got %h expected %h", oW0, INIT); end
        checks++; if (oW1 !== INIT) begin errors++; $display("FAIL rstmid_w1: got %h expected %h", oW1, INIT); end
        checks++; if (oW2 !== INIT) begin errors++; $display("FAIL rstmid_w2: got %h expected %h", oW2, INIT); end
        checks++; if (oBUSY !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", oBUSY); end
        for (int t = 0; t < 60; t++) begin
            tick();
            if (oDONE === 1'b1 || oW0 !== INIT || oW1 !== INIT || oW2 !== INIT) done_cnt++;
        end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL rstmid_quiet: got %0d bad cycles expected 0", done_cnt); end
        mw[0] = INIT; mw[1] = INIT; mw[2] = INIT;
        model_update(32'h3e800000, 32'h3f800000, 32'h00000000);
        start_update(32'h3e800000, 32'h3f800000, 32'h00000000);
        wait_done(1, lat);
        checks++; if (lat !== 40) begin errors++; $display("FAIL rstmid_latency: got %0d expected 40", lat); end
        checks++; if (oW0 !== mw[0]) begin errors++; $display("FAIL rstmid_new_w0: got %h expected %h", oW0, mw[0]); end
        checks++; if (oW1 !== mw[1]) begin errors++; $display("FAIL rstmid_new_w1: got %h expected %h", oW1, mw[1]); end
        checks++; if (oW2 !== mw[2]) begin errors++; $display("FAIL rstmid_new_w2: got %h expected %h", oW2, mw[2]); end
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [31:0] d, x0, x1, ld;
        logic [1:0]  li;
        do_reset();
        for (int it = 0; it < 12; it++) begin
            if (it % 3 == 1) begin
                li = 2'($urandom_range(0, 3));
                ld = rnd_fp(4.0);
                iLOAD = 1'b1; iLOAD_IDX = li; iLOAD_DATA = ld;
                tick();
                iLOAD = 1'b0;
                if (li != 2'd3) mw[li] = ld;
            end
            d  = rnd_fp(16.0);
            x0 = rnd_fp(8.0);
            x1 = rnd_fp(8.0);
            model_update(d, x0, x1);
            start_update(d, x0, x1);
            checks++; if (oBUSY !== 1'b1) begin errors++; $display("FAIL b2b_busy[%0d]: got %b expected 1", it, oBUSY); end
            wait_done(1, lat);
            checks++; if (lat !== 40) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d expected 40", it, lat); end
            checks++; if (oW0 !== mw[0]) begin errors++; $display("FAIL b2b_w0[%0d]: got %h expected %h", it, oW0, mw[0]); end
            checks++; if (oW1 !== mw[1]) begin errors++; $display("FAIL b2b_w1[%0d]: got %h expected %h", it, oW1, mw[1]); end
            checks++; if (oW2 !== mw[2]) begin errors++; $display("FAIL b2b_w2[%0d]: got %h expected %h", it, oW2, mw[2]); end
        end
    endtask

    initial begin
        iRST = 1'b0; iSTART = 1'b0; iDELTA = '0; iX0 = '0; iX1 = '0;
        iLOAD = 1'b0; iLOAD_IDX = '0; iLOAD_DATA = '0;
        test_reset();
        test_basic();
        test_negative();
        test_restart_ignored();
        test_load();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/update_weight_mid.md
UPDATE_WEIGHT_MID -- requirements
Module: update_weight_mid

Interface
REQ-001 SHALL have parameter INIT_W0, 32'h3f000000 (0.5): reset value of weight 0 (input x0).
REQ-002 SHALL have parameter INIT_W1, 32'h3f000000 (0.5): reset value of weight 1 (input x1).
REQ-003 SHALL have parameter INIT_W2, 32'h3f000000 (0.5): reset value of weight 2 (bias).
REQ-004 SHALL have ports, in this order: iCLK in 1, sole clock; reset is synchronous and active-high.
REQ-005 iRST in 1: synchronous active-high reset.
REQ-006 iSTART in 1: one-cycle request to apply one update.
REQ-007 iDELTA in 32: IEEE-754 single hidden-node delta (mu*value*error, already scaled).
REQ-008 iX0, iX1 in 32 each: IEEE-754 single inputs feeding this hidden node.
REQ-009 iLOAD in 1, iLOAD_IDX in 2, iLOAD_DATA in 32: direct weight write.
REQ-010 oW0, oW1, oW2 out 32 each: current weights.
REQ-011 oBUSY out 1: update in progress. oDONE out 1: one-cycle pulse when update completes.

Function
REQ-012 SHALL compute, per index i in 0..2: w[i] <= w[i] + iDELTA*x[i], with x2 = 1.0 (32'h3f800000).
REQ-013 SHALL capture iDELTA, iX0, iX1 on the iSTART cycle; later input changes SHALL NOT affect the update.
REQ-014 FSM states SHALL be IDLE, MUL, ADD, WB, DONE.
REQ-015 IDLE: iSTART=1 and iLOAD=0 -> MUL, index=0, oBUSY=1 next cycle.
REQ-016 MUL: operands (delta, x[index]) go to the multiplier; SHALL hold for FP_MULT_LAT cycles, then -> ADD.
REQ-017 ADD: operands (product, w[index]) go to the adder; SHALL hold for FP_ADD_LAT cycles, then -> WB.
REQ-018 WB: adder result SHALL be written to w[index] for one cycle. index<2 -> index+1, MUL. index=2 -> DONE.
REQ-019 DONE: oDONE=1 for exactly one cycle, oBUSY=0, -> IDLE.
REQ-020 Latency: with iSTART sampled at edge 0, oDONE SHALL be high in cycle 1+3*(FP_MULT_LAT+FP_ADD_LAT+1) = 40 with default constants. The next iSTART SHALL be accepted in the cycle after DONE.
REQ-021 iSTART while oBUSY=1 or in DONE SHALL be ignored and SHALL NOT be queued.
REQ-022 iLOAD in IDLE: iLOAD_DATA SHALL be written to w[iLOAD_IDX] for idx 0..2. idx 3 SHALL be ignored.
REQ-023 iLOAD outside IDLE SHALL be ignored.
REQ-024 iLOAD and iSTART in the same IDLE cycle: the load takes effect and iSTART is dropped.
REQ-025 oW0..oW2 SHALL change only on WB or a load; oW[index] SHALL update on the cycle after WB.
REQ-026 FP exceptions (NaN/Inf) SHALL pass through unmodified; no flags.

Reset
REQ-027 iRST=1 at a clock edge SHALL force IDLE, index=0, oBUSY=0, oDONE=0, oW0/1/2 = INIT_W0/1/2, and clear captured operands.
REQ-028 Reset mid-update SHALL abandon the update: no partial WB after reset, and no oDONE.
REQ-029 Reset SHALL take priority over iSTART and iLOAD in the same cycle.

Structure
REQ-030 Package nn_pkg SHALL hold FP_MULT_LAT=5, FP_ADD_LAT=7, FP_ONE=32'h3f800000, and the FSM state enum.
REQ-031 SHALL instantiate the existing fp_multiplier and fp_adder cores once each, shared across indices.
REQ-032 No new sub-module; the latency counter and FSM SHALL be local.

Verification
REQ-033 Bench SHALL cover: reset then idle -> oW0..2=3f000000, oBUSY=0, oDONE=0.
REQ-034 Bench SHALL cover: iDELTA=3e800000, iX0=3f800000, iX1=0 -> oW0=3f400000, oW1=3f000000, oW2=3f400000; oDONE at cycle 40.
REQ-035 Bench SHALL cover: iDELTA=be800000 (-0.25), iX0=iX1=3f800000 -> all weights 3e800000 (0.25).
REQ-036 Bench SHALL cover: iSTART re-asserted at cycles 5 and 39 of an update -> exactly one oDONE, weights updated once.
REQ-037 Bench SHALL cover: iLOAD idx1=40000000 together with iSTART in IDLE -> oW1=40000000, oBUSY stays 0; idx3 load -> no change.
REQ-038 Bench SHALL cover: iRST at cycle 20 of an update -> weights return to INIT, no oDONE, new iSTART completes normally.
